// File: rtl/rv32v_types_pkg.sv
// Shared vector-unit types: functional-unit encoding and sequencer state codes.
package rv32v_types_pkg;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_DIV = 2'd2,
        FU_LSU = 2'd3
    } fu_t;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t SEQ_IDLE    = 2'd0;
    localparam seq_state_t SEQ_ISSUE   = 2'd1;
    localparam seq_state_t SEQ_WAIT_FU = 2'd2;
    localparam seq_state_t SEQ_DONE    = 2'd3;

    // Units whose lanes report completion through fu_done instead of finishing in one beat.
    function automatic logic is_multicycle(input fu_t fu);
        return (fu == FU_MUL) || (fu == FU_DIV);
    endfunction

endpackage

// File: rtl/vector_elem_qualify.sv
// Per-lane element qualifiers: body-range test and write-enable mask.
module vector_elem_qualify #(
    parameter int IW = 8
) (
    input  logic [IW-1:0] idx,
    input  logic [IW-1:0] vl,
    input  logic [IW-1:0] vstart,
    input  logic          vm,
    input  logic          v0_bit,
    output logic          active,
    output logic          mask
);

    // Prestart and tail elements are inactive; active elements write only when unmasked or v0 is set.
    always_comb begin
        active = (idx >= vstart) && (idx < vl);
        mask   = active && (vm || v0_bit);
    end

endmodule

// File: rtl/vector_element_sequencer.sv
// Walks element pairs from vstart to vl-1 for two lanes, honouring stalls and multi-cycle FU completion.
module vector_element_sequencer
    import rv32v_types_pkg::*;
#(
    parameter int VLMAX = 128,
    parameter int IW    = $clog2(VLMAX) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [IW-1:0]    vl,
    input  logic [IW-1:0]    vstart,
    input  logic             vm,
    input  fu_t              fu_type,
    input  logic [VLMAX-1:0] v0_bits,
    input  logic             stall_e_m,
    input  logic [1:0]       fu_done,
    output logic             issue_valid,
    output logic [IW-1:0]    offset0,
    output logic [IW-1:0]    offset1,
    output logic [1:0]       lane_active,
    output logic [1:0]       lane_mask,
    output logic             first_beat,
    output logic             busy,
    output logic             done
);

    localparam int AW = $clog2(VLMAX);

    seq_state_t       state_r,  state_nx_s;
    logic [IW-1:0]    base_r,   base_nx_s;
    logic [IW-1:0]    base0_r,  base0_nx_s;
    logic [IW-1:0]    vl_r,     vl_nx_s;
    logic [IW-1:0]    vstart_r, vstart_nx_s;
    logic             vm_r,     vm_nx_s;
    fu_t              fu_r,     fu_nx_s;
    logic [VLMAX-1:0] v0_r,     v0_nx_s;
    logic [1:0]       seen_r,   seen_nx_s;
    logic             advance_s;
    logic [IW-1:0]    off1_nx_s;
    logic [1:0]       act_nx_s;
    logic [1:0]       msk_nx_s;
    logic             v0_bit0_s;
    logic             v0_bit1_s;

    logic             issue_valid_r;
    logic [IW-1:0]    offset0_r;
    logic [IW-1:0]    offset1_r;
    logic [1:0]       lane_active_r;
    logic [1:0]       lane_mask_r;
    logic             first_beat_r;
    logic             busy_r;
    logic             done_r;

    // Next-state, counter and instruction-latch logic.
    always_comb begin
        state_nx_s  = state_r;
        base_nx_s   = base_r;
        base0_nx_s  = base0_r;
        vl_nx_s     = vl_r;
        vstart_nx_s = vstart_r;
        vm_nx_s     = vm_r;
        fu_nx_s     = fu_r;
        v0_nx_s     = v0_r;
        seen_nx_s   = seen_r;
        advance_s   = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (start) begin
                    vl_nx_s     = vl;
                    vstart_nx_s = vstart;
                    vm_nx_s     = vm;
                    fu_nx_s     = fu_type;
                    v0_nx_s     = v0_bits;
                    base_nx_s   = {vstart[IW-1:1], 1'b0};
                    base0_nx_s  = {vstart[IW-1:1], 1'b0};
                    state_nx_s  = (vstart >= vl) ? SEQ_DONE : SEQ_ISSUE;
                end else begin
                    state_nx_s  = SEQ_IDLE;
                end
            end
            SEQ_ISSUE: begin
                if (stall_e_m) begin
                    state_nx_s = SEQ_ISSUE;
                end else if (is_multicycle(fu_r)) begin
                    // Registered lane_active still describes the beat being handed over.
                    seen_nx_s  = ~lane_active_r | fu_done;
                    state_nx_s = SEQ_WAIT_FU;
                end else begin
                    advance_s  = 1'b1;
                end
            end
            SEQ_WAIT_FU: begin
                seen_nx_s = seen_r | fu_done;
                advance_s = (seen_nx_s == 2'b11);
            end
            SEQ_DONE: begin
                state_nx_s = SEQ_IDLE;
            end
            default: begin
                state_nx_s = SEQ_IDLE;
            end
        endcase
        if (advance_s) begin
            if ((base_r + IW'(2)) >= vl_r) begin
                state_nx_s = SEQ_DONE;
            end else begin
                base_nx_s  = base_r + IW'(2);
                state_nx_s = SEQ_ISSUE;
            end
        end else begin
            base_nx_s = base_nx_s;
        end
    end

    // The v0 bit only matters for active lanes, whose index is below vl and so inside v0.
    always_comb begin
        off1_nx_s = base_nx_s + IW'(1);
        v0_bit0_s = v0_nx_s[base_nx_s[AW-1:0]];
        v0_bit1_s = v0_nx_s[off1_nx_s[AW-1:0]];
    end

    vector_elem_qualify #(.IW(IW)) u_qual_lane0 (
        .idx    (base_nx_s),
        .vl     (vl_nx_s),
        .vstart (vstart_nx_s),
        .vm     (vm_nx_s),
        .v0_bit (v0_bit0_s),
        .active (act_nx_s[0]),
        .mask   (msk_nx_s[0])
    );

    vector_elem_qualify #(.IW(IW)) u_qual_lane1 (
        .idx    (off1_nx_s),
        .vl     (vl_nx_s),
        .vstart (vstart_nx_s),
        .vm     (vm_nx_s),
        .v0_bit (v0_bit1_s),
        .active (act_nx_s[1]),
        .mask   (msk_nx_s[1])
    );

    // State, latches and output registers; outputs are decoded from the next state so they align with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= SEQ_IDLE;
            base_r        <= {IW{1'b0}};
            base0_r       <= {IW{1'b0}};
            vl_r          <= {IW{1'b0}};
            vstart_r      <= {IW{1'b0}};
            vm_r          <= 1'b0;
            fu_r          <= FU_ALU;
            v0_r          <= {VLMAX{1'b0}};
            seen_r        <= 2'b00;
            issue_valid_r <= 1'b0;
            offset0_r     <= {IW{1'b0}};
            offset1_r     <= {IW{1'b0}};
            lane_active_r <= 2'b00;
            lane_mask_r   <= 2'b00;
            first_beat_r  <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            base_r        <= base_nx_s;
            base0_r       <= base0_nx_s;
            vl_r          <= vl_nx_s;
            vstart_r      <= vstart_nx_s;
            vm_r          <= vm_nx_s;
            fu_r          <= fu_nx_s;
            v0_r          <= v0_nx_s;
            seen_r        <= seen_nx_s;
            issue_valid_r <= (state_nx_s == SEQ_ISSUE);
            offset0_r     <= (state_nx_s == SEQ_ISSUE) ? base_nx_s : {IW{1'b0}};
            offset1_r     <= (state_nx_s == SEQ_ISSUE) ? off1_nx_s : {IW{1'b0}};
            lane_active_r <= (state_nx_s == SEQ_ISSUE) ? act_nx_s  : 2'b00;
            lane_mask_r   <= (state_nx_s == SEQ_ISSUE) ? msk_nx_s  : 2'b00;
            first_beat_r  <= (state_nx_s == SEQ_ISSUE) && (base_nx_s == base0_nx_s);
            busy_r        <= (state_nx_s != SEQ_IDLE);
            done_r        <= (state_nx_s == SEQ_DONE);
        end
    end

    assign issue_valid = issue_valid_r;
    assign offset0     = offset0_r;
    assign offset1     = offset1_r;
    assign lane_active = lane_active_r;
    assign lane_mask   = lane_mask_r;
    assign first_beat  = first_beat_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Directed bench for vector_element_sequencer with hand-computed beat expectations.
module tb_vector_element_sequencer;
    import rv32v_types_pkg::*;

    localparam int VLMAX = 128;
    localparam int IW    = 8;

    logic             CLK;
    logic             RST;
    logic             start;
    logic [IW-1:0]    vl;
    logic [IW-1:0]    vstart;
    logic             vm;
    fu_t              fu_type;
    logic [VLMAX-1:0] v0_bits;
    logic             stall_e_m;
    logic [1:0]       fu_done;
    logic             issue_valid;
    logic [IW-1:0]    offset0;
    logic [IW-1:0]    offset1;
    logic [1:0]       lane_active;
    logic [1:0]       lane_mask;
    logic             first_beat;
    logic             busy;
    logic             done;

    int tests_run = 0;
    int tests_failed = 0;

    vector_element_sequencer #(.VLMAX(VLMAX)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .vl          (vl),
        .vstart      (vstart),
        .vm          (vm),
        .fu_type     (fu_type),
        .v0_bits     (v0_bits),
        .stall_e_m   (stall_e_m),
        .fu_done     (fu_done),
        .issue_valid (issue_valid),
        .offset0     (offset0),
        .offset1     (offset1),
        .lane_active (lane_active),
        .lane_mask   (lane_mask),
        .first_beat  (first_beat),
        .busy        (busy),
        .done        (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one cycle of lane outputs; o0 is the expected lane-0 offset when a beat is present.
    task automatic beat(input string tag, input logic iv, input int o0, input logic [1:0] act,
                        input logic [1:0] msk, input logic fb);
        chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(iv));
        if (iv) begin
            chk({tag, ".offset0"}, 32'(offset0), 32'(o0));
            chk({tag, ".offset1"}, 32'(offset1), 32'(o0 + 1));
        end
        chk({tag, ".lane_active"}, 32'(lane_active), 32'(act));
        chk({tag, ".lane_mask"}, 32'(lane_mask), 32'(msk));
        chk({tag, ".first_beat"}, 32'(first_beat), 32'(fb));
    endtask

    task automatic issue_start(input int l, input int s, input logic m, input fu_t f,
                               input logic [VLMAX-1:0] v0);
        start   = 1'b1;
        vl      = IW'(l);
        vstart  = IW'(s);
        vm      = m;
        fu_type = f;
        v0_bits = v0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".outs"}, {issue_valid, offset0, offset1, lane_active, lane_mask,
                             first_beat, busy, done, 10'd0}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; vl = '0; vstart = '0; vm = 1'b0; fu_type = FU_ALU;
        v0_bits = '0; stall_e_m = 1'b0; fu_done = 2'b00;
        cyc(); cyc();
        RST = 1'b0;
        check_all_zero("reset");

        // vl=5, vstart=0, unmasked ALU.
        issue_start(5, 0, 1'b1, FU_ALU, '0);
        cyc(); start = 1'b0;
        beat("alu5.b1", 1'b1, 0, 2'b11, 2'b11, 1'b1);
        chk("alu5.busy", 32'(busy), 32'd1);
        cyc(); beat("alu5.b2", 1'b1, 2, 2'b11, 2'b11, 1'b0);
        cyc(); beat("alu5.b3", 1'b1, 4, 2'b01, 2'b01, 1'b0);
        chk("alu5.nodone_b3", 32'(done), 32'd0);
        cyc(); chk("alu5.done", 32'(done), 32'd1);
        chk("alu5.done_noissue", 32'(issue_valid), 32'd0);
        cyc(); chk("alu5.idle_busy", 32'(busy), 32'd0);
        chk("alu5.done_pulse", 32'(done), 32'd0);

        // vl=6, vstart=3, masked by v0=101010.
        issue_start(6, 3, 1'b0, FU_ALU, 128'b101010);
        cyc(); start = 1'b0;
        beat("msk.b1", 1'b1, 2, 2'b10, 2'b10, 1'b1);
        cyc(); beat("msk.b2", 1'b1, 4, 2'b11, 2'b10, 1'b0);
        cyc(); chk("msk.done", 32'(done), 32'd1);
        cyc(); chk("msk.idle_busy", 32'(busy), 32'd0);

        // Empty instruction vl=0, started in the cycle right after the previous busy drop.
        issue_start(0, 0, 1'b1, FU_ALU, '0);
        cyc(); start = 1'b0;
        chk("vl0.done", 32'(done), 32'd1);
        chk("vl0.noissue", 32'(issue_valid), 32'd0);
        chk("vl0.busy", 32'(busy), 32'd1);
        cyc(); chk("vl0.after", {30'd0, issue_valid, busy}, 32'd0);

        // Empty instruction vstart=vl=8.
        issue_start(8, 8, 1'b1, FU_ALU, '0);
        cyc(); start = 1'b0;
        chk("vs8.done", 32'(done), 32'd1);
        chk("vs8.noissue", 32'(issue_valid), 32'd0);
        cyc(); chk("vs8.after", {30'd0, issue_valid, done}, 32'd0);

        // vl=4 MUL: lane 1 done 3 cycles before lane 0, then a 2-cycle stall on beat 2.
        issue_start(4, 0, 1'b1, FU_MUL, '0);
        cyc(); start = 1'b0;
        beat("mul.b1", 1'b1, 0, 2'b11, 2'b11, 1'b1);
        cyc(); beat("mul.w1", 1'b0, 0, 2'b00, 2'b00, 1'b0);
        fu_done = 2'b10;
        cyc(); fu_done = 2'b00;
        chk("mul.w2", 32'(issue_valid), 32'd0);
        cyc(); chk("mul.w3", 32'(issue_valid), 32'd0);
        cyc(); chk("mul.w4", 32'(issue_valid), 32'd0);
        fu_done = 2'b01;
        cyc(); fu_done = 2'b00;
        beat("mul.b2", 1'b1, 2, 2'b11, 2'b11, 1'b0);
        stall_e_m = 1'b1;
        cyc(); beat("mul.st1", 1'b1, 2, 2'b11, 2'b11, 1'b0);
        cyc(); beat("mul.st2", 1'b1, 2, 2'b11, 2'b11, 1'b0);
        stall_e_m = 1'b0;
        fu_done = 2'b11;
        cyc(); fu_done = 2'b00;
        chk("mul.w_b2", {30'd0, issue_valid, done}, 32'd0);
        cyc(); chk("mul.done", 32'(done), 32'd1);
        cyc(); chk("mul.idle", 32'(busy), 32'd0);

        // Reset while waiting on the FU.
        issue_start(2, 0, 1'b1, FU_DIV, '0);
        cyc(); start = 1'b0;
        chk("rst.b1", 32'(issue_valid), 32'd1);
        cyc(); chk("rst.wait_busy", 32'(busy), 32'd1);
        RST = 1'b1;
        cyc(); RST = 1'b0;
        check_all_zero("rst.mid");

        // A start while busy is ignored.
        issue_start(4, 0, 1'b1, FU_ALU, '0);
        cyc();
        beat("ign.b1", 1'b1, 0, 2'b11, 2'b11, 1'b1);
        issue_start(20, 10, 1'b1, FU_ALU, '0);
        cyc(); start = 1'b0;
        beat("ign.b2", 1'b1, 2, 2'b11, 2'b11, 1'b0);
        cyc(); chk("ign.done", 32'(done), 32'd1);
        chk("ign.noissue", 32'(issue_valid), 32'd0);
        cyc(); chk("ign.idle", 32'(busy), 32'd0);

        // vl=128 near the top of the vector: last pair (126,127) must not wrap.
        begin
            logic [VLMAX-1:0] v0_top;
            v0_top = '0;
            v0_top[127] = 1'b1;
            issue_start(128, 124, 1'b0, FU_ALU, v0_top);
        end
        cyc(); start = 1'b0;
        beat("top.b1", 1'b1, 124, 2'b11, 2'b00, 1'b1);
        cyc(); beat("top.b2", 1'b1, 126, 2'b11, 2'b10, 1'b0);
        cyc(); chk("top.done", 32'(done), 32'd1);
        chk("top.noissue", 32'(issue_valid), 32'd0);
        cyc(); chk("top.idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
